// File: rtl/phase_timer.sv
`default_nettype none
// =============================================================================
// phase_timer : pausable countdown of whole seconds at a selectable clock rate
// Revision 1.0
// =============================================================================
module phase_timer #(
  parameter int BASE_TICKS = 1_000_000,
  parameter int TICK_W     = 32,
  parameter int SEC_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_rst,
  input  logic             start,
  input  logic [SEC_W-1:0] dur_sec,
  input  logic [1:0]       clk_freq,
  input  logic             pause,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             done_pulse,
  output logic [SEC_W-1:0] remaining_sec
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [TICK_W-1:0] tick_cnt;
  logic [SEC_W-1:0]  rem;
  logic [1:0]        freq_lat;
  logic              pulse;

  logic [TICK_W-1:0] limit;
  logic              terminal;

  assign limit    = (TICK_W'(BASE_TICKS) << freq_lat) - TICK_W'(1);
  assign terminal = (tick_cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      rem      <= '0;
      freq_lat <= 2'd0;
      pulse    <= 1'b0;
    end else if (!soft_rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      rem      <= '0;
      freq_lat <= 2'd0;
      pulse    <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            freq_lat <= clk_freq;
            tick_cnt <= '0;
            if (dur_sec != '0) begin
              state <= RUN;
              rem   <= dur_sec;
            end else begin
              state <= DONE;
              rem   <= '0;
              pulse <= 1'b1;
            end
          end
        end
        RUN, PAUSE: begin
          // Leaving PAUSE counts on the same edge, so only cycles spent with
          // paused high are excluded from the phase length.
          if (pause) begin
            state <= PAUSE;
          end else begin
            state <= RUN;
            if (terminal) begin
              tick_cnt <= '0;
              if (rem != '0) rem <= rem - SEC_W'(1);
              if (rem == SEC_W'(1)) begin
                state <= DONE;
                pulse <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state == RUN) || (state == PAUSE);
  assign paused        = (state == PAUSE);
  assign done          = (state == DONE);
  assign done_pulse    = pulse;
  assign remaining_sec = rem;

endmodule
`default_nettype wire

// File: tb/tb_phase_timer.sv
`default_nettype none
// tb_phase_timer : directed scenarios plus randomized traffic against a
// cycle-count reference model (BASE_TICKS = 4).
module tb_phase_timer;

  localparam int BASE = 4;
  localparam int TW   = 8;
  localparam int SW   = 8;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          soft_rst = 1'b1;
  logic          start    = 1'b0;
  logic [SW-1:0] dur_sec  = '0;
  logic [1:0]    clk_freq = 2'd0;
  logic          pause    = 1'b0;
  logic          busy, paused, done, done_pulse;
  logic [SW-1:0] remaining_sec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phase_timer #(.BASE_TICKS(BASE), .TICK_W(TW), .SEC_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .start(start),
    .dur_sec(dur_sec), .clk_freq(clk_freq), .pause(pause),
    .busy(busy), .paused(paused), .done(done), .done_pulse(done_pulse),
    .remaining_sec(remaining_sec)
  );

  // Reference model: counts active (unpaused) cycles since the accepted start;
  // seconds left = duration minus whole periods elapsed.
  int m_phase = 0;  // 0 idle, 1 timing, 2 finished
  int m_dur = 0, m_period = BASE, m_active = 0;
  bit m_paused = 0, m_pulse = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !soft_rst) begin
      m_phase <= 0; m_dur <= 0; m_period <= BASE; m_active <= 0;
      m_paused <= 0; m_pulse <= 0;
    end else begin
      m_pulse <= 0;
      if (m_phase != 1 && start) begin
        m_paused <= 0;
        m_active <= 0;
        if (dur_sec == 0) begin
          m_phase <= 2; m_dur <= 0; m_pulse <= 1;
        end else begin
          m_phase <= 1; m_dur <= int'(dur_sec); m_period <= BASE << clk_freq;
        end
      end else if (m_phase == 1) begin
        if (pause) m_paused <= 1;
        else begin
          m_paused <= 0;
          m_active <= m_active + 1;
          if (m_active + 1 == m_dur * m_period) begin
            m_phase <= 2; m_pulse <= 1;
          end
        end
      end
    end
  end

  function automatic logic [SW+3:0] model_vec();
    logic [SW-1:0] r;
    r = (m_phase == 1) ? SW'(m_dur - m_active / m_period) : '0;
    return {m_phase == 1, m_paused, m_phase == 2, m_pulse, r};
  endfunction

  task automatic test_reset();
    logic [SW+3:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {busy, paused, done, done_pulse, remaining_sec};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_hold got=%h exp=0", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {busy, paused, done, done_pulse, remaining_sec};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_release got=%h exp=0", got);
    end
  endtask

  task automatic test_basic();
    logic [SW+3:0] got, exp;
    start = 1'b1; dur_sec = 8'd3; clk_freq = 2'd0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp = {k < 12, 1'b0, k >= 12, k == 12, (k >= 12) ? 8'd0 : SW'(3 - k / 4)};
      got = {busy, paused, done, done_pulse, remaining_sec};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL basic k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_freq_latch();
    logic [SW+3:0] got, exp;
    start = 1'b1; dur_sec = 8'd2; clk_freq = 2'd3;
    for (int k = 0; k <= 65; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp = {k < 64, 1'b0, k >= 64, k == 64, (k >= 64) ? 8'd0 : SW'(2 - k / 32)};
      got = {busy, paused, done, done_pulse, remaining_sec};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL freq_latch k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 10) clk_freq = 2'd0;
    end
  endtask

  task automatic test_pause();
    logic [SW+3:0] got, exp;
    int act;
    start = 1'b1; dur_sec = 8'd2; clk_freq = 2'd0; pause = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
      act = (k <= 2) ? k : (k <= 7) ? 2 : k - 5;
      exp = {k < 13, (k >= 3 && k <= 7), k >= 13, k == 13,
             (k >= 13) ? 8'd0 : SW'(2 - act / 4)};
      got = {busy, paused, done, done_pulse, remaining_sec};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL pause k=%0d got=%h exp=%h", k, got, exp);
      end
      pause = (k + 1 >= 3) && (k + 1 <= 7);
    end
    pause = 1'b0;
  endtask

  task automatic test_zero_dur();
    logic [SW+3:0] got, exp;
    start = 1'b1; dur_sec = 8'd0; clk_freq = 2'd0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0)      exp = {1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
      else if (k == 1) exp = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      else exp = {k < 6, 1'b0, k >= 6, k == 6, (k < 6) ? 8'd1 : 8'd0};
      got = {busy, paused, done, done_pulse, remaining_sec};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL zero_dur k=%0d got=%h exp=%h", k, got, exp);
      end
      start   = (k == 1);
      dur_sec = (k == 1) ? 8'd1 : 8'd0;
      pause   = (k == 0);
    end
  endtask

  task automatic test_soft_rst();
    logic [SW+3:0] got, exp;
    start = 1'b1; dur_sec = 8'd5; clk_freq = 2'd0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      exp = (k < 6) ? {1'b1, 1'b0, 1'b0, 1'b0, SW'(5 - k / 4)} : '0;
      got = {busy, paused, done, done_pulse, remaining_sec};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL soft_rst k=%0d got=%h exp=%h", k, got, exp);
      end
      start    = (k == 2);
      dur_sec  = (k == 2) ? 8'd9 : 8'd0;
      soft_rst = (k != 5);
    end
    soft_rst = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [SW+3:0] got;
    start = 1'b1; dur_sec = 8'd3; clk_freq = 2'd0;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      pause = (k >= 1);
      if (k >= 2) begin
        n_cmp++;
        if (paused !== 1'b1) begin
          n_err++; $display("FAIL async_pre_paused k=%0d got=%b exp=1", k, paused);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1 got = {busy, paused, done, done_pulse, remaining_sec};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL async_reset got=%h exp=0", got);
    end
    @(negedge clk);
    rst_n = 1'b1; pause = 1'b0;
    @(negedge clk);
    got = {busy, paused, done, done_pulse, remaining_sec};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL async_release got=%h exp=0", got);
    end
  endtask

  task automatic test_random();
    logic [SW+3:0] got, exp;
    int bad = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      got = {busy, paused, done, done_pulse, remaining_sec};
      exp = model_vec();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        if (bad < 10) $display("FAIL random c=%0d got=%h exp=%h", c, got, exp);
        bad++;
      end
      start    = ($urandom_range(0, 19) == 0);
      dur_sec  = SW'($urandom_range(0, 3));
      clk_freq = 2'($urandom_range(0, 3));
      pause    = ($urandom_range(0, 7) == 0);
      soft_rst = ($urandom_range(0, 199) != 0);
    end
    start = 1'b0; pause = 1'b0; soft_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_freq_latch();
    test_pause();
    test_zero_dur();
    test_soft_rst();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
